// File: rtl/astro_target_engine_pkg.sv
// Shared definitions for the astro target engine: state encoding,
// playfield bounds, bullet launch point and the hit-window helper.
package astro_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_WIN  = 2'd2,
        ST_LOSE = 2'd3
    } state_e;

    // Target bounce limits (inclusive).
    localparam logic [9:0] X_MIN     = 10'd10;
    localparam logic [9:0] X_MAX     = 10'd612;
    // Ship travel limits: it only steps while strictly inside these.
    localparam logic [9:0] SHIP_MIN  = 10'd30;
    localparam logic [9:0] SHIP_MAX  = 10'd610;
    localparam logic [9:0] SHIP_X0   = 10'd400;
    localparam logic [9:0] BULLET_Y0 = 10'd435;
    localparam logic [9:0] HIT_HALF  = 10'd10;
    // Target i starts at TARGET_X0 + i*TARGET_DX.
    localparam int         TARGET_X0 = 20;
    localparam int         TARGET_DX = 40;

    // |a-b| <= HIT_HALF, evaluated on 11-bit values so a+10 cannot wrap.
    function automatic logic within_hit(input logic [9:0] a, input logic [9:0] b);
        return (({1'b0, a} + {1'b0, HIT_HALF}) >= {1'b0, b}) &&
               (({1'b0, b} + {1'b0, HIT_HALF}) >= {1'b0, a});
    endfunction

endpackage

// File: rtl/astro_target_engine_if.sv
// Player/game bus of the target engine.
// Timing contract: there is no valid/ready handshake. tick is a one-clock
// update enable; start and the buttons are only looked at on clocks where
// tick=1. All outputs are registered and change only on clocks where tick=1,
// except level_done, which is high for exactly the clock after a winning tick.
interface astro_target_engine_if #(
    parameter int NUM_TARGETS = 4
);
    logic                      tick;
    logic                      start;
    logic                      btn_left;
    logic                      btn_right;
    logic                      btn_fire;
    logic [9:0]                ship_x;
    logic                      bullet_active;
    logic [9:0]                bullet_x;
    logic [9:0]                bullet_y;
    logic [10*NUM_TARGETS-1:0] target_x;
    logic [NUM_TARGETS-1:0]    target_hit;
    logic [3:0]                shots_left;
    logic [7:0]                score;
    logic [1:0]                state;
    logic                      level_done;

    modport master (
        output tick, start, btn_left, btn_right, btn_fire,
        input  ship_x, bullet_active, bullet_x, bullet_y, target_x,
               target_hit, shots_left, score, state, level_done
    );

    modport slave (
        input  tick, start, btn_left, btn_right, btn_fire,
        output ship_x, bullet_active, bullet_x, bullet_y, target_x,
               target_hit, shots_left, score, state, level_done
    );
endinterface

// File: rtl/astro_target.sv
// One moving target: x position, travel direction and hit flag.
// Bounces between X_MIN and X_MAX; a hit freezes it until the next load.
module astro_target
    import astro_pkg::*;
#(
    parameter int X0    = 20,
    parameter bit LEFT0 = 1'b0,
    parameter int STEP  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       step_en,
    input  logic       hit_set,
    output logic [9:0] x,
    output logic       hit
);
    logic [9:0] x_q, x_d;
    logic       left_q, left_d;
    logic       hit_q, hit_d;

    // Reload, freeze on hit, or bounce-then-step on a play tick.
    always_comb begin
        x_d    = x_q;
        left_d = left_q;
        hit_d  = hit_q;
        if (load) begin
            x_d    = 10'(X0);
            left_d = LEFT0;
            hit_d  = 1'b0;
        end else if (hit_set) begin
            hit_d = 1'b1;
        end else if (step_en && !hit_q) begin
            if ({1'b0, x_q} >= {1'b0, X_MAX}) begin
                left_d = 1'b1;
            end else if ({1'b0, x_q} <= {1'b0, X_MIN}) begin
                left_d = 1'b0;
            end
            x_d = left_d ? (x_q - 10'(STEP)) : (x_q + 10'(STEP));
        end
    end

    // Target state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q    <= 10'(X0);
            left_q <= LEFT0;
            hit_q  <= 1'b0;
        end else begin
            x_q    <= x_d;
            left_q <= left_d;
            hit_q  <= hit_d;
        end
    end

    assign x   = x_q;
    assign hit = hit_q;
endmodule

// File: rtl/astro_target_engine.sv
// Shooting-gallery engine: ship, single bullet, ammo, score, level FSM and
// hit arbitration over NUM_TARGETS bouncing targets.
module astro_target_engine
    import astro_pkg::*;
#(
    parameter int NUM_TARGETS = 4,
    parameter int AMMO        = 6,
    parameter int TARGET_Y0   = 100,
    parameter int TARGET_DY   = 50,
    parameter int TARGET_STEP = 2,
    parameter int SHIP_STEP   = 5,
    parameter int BULLET_STEP = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    astro_target_engine_if.slave  bus
);
    state_e                    state_q, state_d;
    logic [9:0]                ship_x_q, ship_x_d;
    logic                      bullet_active_q, bullet_active_d;
    logic [9:0]                bullet_x_q, bullet_x_d;
    logic [9:0]                bullet_y_q, bullet_y_d;
    logic [3:0]                shots_left_q, shots_left_d;
    logic [7:0]                score_q, score_d;
    logic                      level_done_q, level_done_d;

    logic [10*NUM_TARGETS-1:0] target_x;
    logic [NUM_TARGETS-1:0]    target_hit;
    logic [NUM_TARGETS-1:0]    hit_vec;
    logic                      play_tick, load, all_hit_next, lose_next;

    assign play_tick = bus.tick && (state_q == ST_PLAY);
    assign load      = bus.tick && bus.start && (state_q != ST_PLAY);

    for (genvar g = 0; g < NUM_TARGETS; g++) begin : g_tgt
        astro_target #(
            .X0    (TARGET_X0 + TARGET_DX * g),
            .LEFT0 ((g % 2) == 1),
            .STEP  (TARGET_STEP)
        ) u_tgt (
            .clk     (clk),
            .reset   (reset),
            .load    (load),
            .step_en (play_tick),
            .hit_set (hit_vec[g]),
            .x       (target_x[g*10 +: 10]),
            .hit     (target_hit[g])
        );
    end

    // One-hot hit select on pre-tick coordinates; lowest index wins.
    always_comb begin
        hit_vec = '0;
        for (int i = NUM_TARGETS - 1; i >= 0; i--) begin
            if (play_tick && bullet_active_q && !target_hit[i] &&
                within_hit(bullet_x_q, target_x[i*10 +: 10]) &&
                within_hit(bullet_y_q, 10'(TARGET_Y0 + i * TARGET_DY))) begin
                hit_vec    = '0;
                hit_vec[i] = 1'b1;
            end
        end
        all_hit_next = &(target_hit | hit_vec);
    end

    // Ship, bullet, ammo and score updates.
    always_comb begin
        ship_x_d        = ship_x_q;
        bullet_active_d = bullet_active_q;
        bullet_x_d      = bullet_x_q;
        bullet_y_d      = bullet_y_q;
        shots_left_d    = shots_left_q;
        score_d         = score_q;
        if (load) begin
            ship_x_d        = SHIP_X0;
            bullet_active_d = 1'b0;
            shots_left_d    = 4'(AMMO);
            if (state_q == ST_LOSE) begin
                score_d = 8'd0;
            end
        end else if (play_tick) begin
            if (bus.btn_right && !bus.btn_left && (ship_x_q < SHIP_MAX)) begin
                ship_x_d = ship_x_q + 10'(SHIP_STEP);
            end else if (bus.btn_left && !bus.btn_right && (ship_x_q > SHIP_MIN)) begin
                ship_x_d = ship_x_q - 10'(SHIP_STEP);
            end
            if (|hit_vec) begin
                bullet_active_d = 1'b0;
                if (score_q != 8'hFF) begin
                    score_d = score_q + 8'd1;
                end
            end else if (bullet_active_q) begin
                if (bullet_y_q < 10'(BULLET_STEP)) begin
                    bullet_active_d = 1'b0;
                end else begin
                    bullet_y_d = bullet_y_q - 10'(BULLET_STEP);
                end
            end else if (bus.btn_fire && (shots_left_q != 4'd0)) begin
                bullet_active_d = 1'b1;
                bullet_x_d      = ship_x_q;
                bullet_y_d      = BULLET_Y0;
                shots_left_d    = shots_left_q - 4'd1;
            end
        end
        lose_next = (shots_left_d == 4'd0) && !bullet_active_d && !all_hit_next;
    end

    // Level FSM next state; a win outranks running out of ammo.
    always_comb begin
        state_d      = state_q;
        level_done_d = 1'b0;
        case (state_q)
            ST_PLAY: begin
                if (play_tick) begin
                    if (all_hit_next) begin
                        state_d      = ST_WIN;
                        level_done_d = 1'b1;
                    end else if (lose_next) begin
                        state_d = ST_LOSE;
                    end
                end
            end
            default: begin
                if (load) begin
                    state_d = ST_PLAY;
                end
            end
        endcase
    end

    // FSM state and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            ship_x_q        <= SHIP_X0;
            bullet_active_q <= 1'b0;
            bullet_x_q      <= 10'd0;
            bullet_y_q      <= 10'd0;
            shots_left_q    <= 4'(AMMO);
            score_q         <= 8'd0;
            level_done_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            ship_x_q        <= ship_x_d;
            bullet_active_q <= bullet_active_d;
            bullet_x_q      <= bullet_x_d;
            bullet_y_q      <= bullet_y_d;
            shots_left_q    <= shots_left_d;
            score_q         <= score_d;
            level_done_q    <= level_done_d;
        end
    end

    // Drive registered results onto the bus.
    always_comb begin
        bus.state         = state_q;
        bus.ship_x        = ship_x_q;
        bus.bullet_active = bullet_active_q;
        bus.bullet_x      = bullet_x_q;
        bus.bullet_y      = bullet_y_q;
        bus.target_x      = target_x;
        bus.target_hit    = target_hit;
        bus.shots_left    = shots_left_q;
        bus.score         = score_q;
        bus.level_done    = level_done_q;
    end
endmodule

// File: tb/tb_astro_target_engine.sv
// Bench for astro_target_engine: a default-parameter instance tracked by a
// game model through an expected-snapshot queue, plus two small instances
// for the overlapping-target and single-shot-win cases.
module tb_astro_target_engine;
    localparam int W = 90;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    astro_target_engine_if #(.NUM_TARGETS(4)) bus_m ();
    astro_target_engine_if #(.NUM_TARGETS(2)) bus_o ();
    astro_target_engine_if #(.NUM_TARGETS(1)) bus_a ();

    astro_target_engine dut (.clk(clk), .reset(reset), .bus(bus_m.slave));
    astro_target_engine #(.NUM_TARGETS(2), .TARGET_Y0(430), .TARGET_DY(0), .SHIP_STEP(180))
        dut_ov (.clk(clk), .reset(reset), .bus(bus_o.slave));
    astro_target_engine #(.NUM_TARGETS(1), .AMMO(1), .TARGET_Y0(430), .SHIP_STEP(180))
        dut_a1 (.clk(clk), .reset(reset), .bus(bus_a.slave));

    // ---------------- game model of the default instance ----------------
    int m_state, m_ship, m_bx, m_by, m_shots, m_score;
    bit m_ba, m_done;
    int m_tx[4];
    bit m_dl[4];
    bit m_hit[4];

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic void model_init();
        m_ship = 400; m_ba = 0; m_shots = 6;
        for (int i = 0; i < 4; i++) begin
            m_tx[i] = 20 + 40 * i; m_dl[i] = (i % 2 == 1); m_hit[i] = 0;
        end
    endfunction

    function automatic void model_reset();
        model_init();
        m_state = 0; m_score = 0; m_done = 0; m_bx = 0; m_by = 0;
    endfunction

    function automatic void model_tick(input bit st, input bit l, input bit r, input bit f);
        int hi, old_ship;
        bit all;
        m_done = 0;
        if (m_state != 1) begin
            if (st) begin
                if (m_state == 3) m_score = 0;
                model_init();
                m_state = 1;
            end
            return;
        end
        old_ship = m_ship;
        if (r && !l && m_ship < 610) m_ship += 5;
        else if (l && !r && m_ship > 30) m_ship -= 5;
        hi = -1;
        if (m_ba)
            for (int i = 0; i < 4; i++)
                if (hi < 0 && !m_hit[i] && iabs(m_bx - m_tx[i]) <= 10 &&
                    iabs(m_by - (100 + 50 * i)) <= 10) hi = i;
        for (int i = 0; i < 4; i++) begin
            if (!m_hit[i] && i != hi) begin
                if (m_tx[i] >= 612) m_dl[i] = 1;
                else if (m_tx[i] <= 10) m_dl[i] = 0;
                m_tx[i] += m_dl[i] ? -2 : 2;
            end
        end
        if (hi >= 0) begin
            m_hit[hi] = 1; m_ba = 0;
            if (m_score < 255) m_score++;
        end else if (m_ba) begin
            if (m_by < 10) m_ba = 0; else m_by -= 10;
        end else if (f && m_shots > 0) begin
            m_ba = 1; m_bx = old_ship; m_by = 435; m_shots--;
        end
        all = m_hit[0] && m_hit[1] && m_hit[2] && m_hit[3];
        if (all) begin m_state = 2; m_done = 1; end
        else if (m_shots == 0 && !m_ba) m_state = 3;
    endfunction

    function automatic logic [W-1:0] model_pack();
        logic [39:0] txv;
        logic [3:0] hv;
        for (int i = 0; i < 4; i++) begin
            txv[i*10 +: 10] = 10'(m_tx[i]); hv[i] = m_hit[i];
        end
        return {2'(m_state), 10'(m_ship), m_ba, m_ba ? 10'(m_bx) : 10'd0,
                m_ba ? 10'(m_by) : 10'd0, 4'(m_shots), 8'(m_score), hv, txv, m_done};
    endfunction

    function automatic logic [W-1:0] dut_pack();
        return {bus_m.state, bus_m.ship_x, bus_m.bullet_active,
                bus_m.bullet_active ? bus_m.bullet_x : 10'd0,
                bus_m.bullet_active ? bus_m.bullet_y : 10'd0,
                bus_m.shots_left, bus_m.score, bus_m.target_hit, bus_m.target_x, bus_m.level_done};
    endfunction

    // ---------------- drivers ----------------
    // One clock on the default instance: drive, predict, then compare snapshot.
    task automatic main_cycle(input bit t, input bit st, input bit l, input bit r, input bit f);
        logic [W-1:0] e, a;
        @(negedge clk);
        bus_m.tick = t; bus_m.start = st; bus_m.btn_left = l; bus_m.btn_right = r; bus_m.btn_fire = f;
        if (t) model_tick(st, l, r, f); else m_done = 0;
        exp_q.push_back(model_pack());
        @(posedge clk);
        #1;
        bus_m.tick = 0; bus_m.start = 0; bus_m.btn_left = 0; bus_m.btn_right = 0; bus_m.btn_fire = 0;
        e = exp_q.pop_front();
        a = dut_pack();
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL scoreboard @%0t: dut=%h model=%h", $time, a, e);
        end
    endtask

    task automatic main_tick(input bit st, input bit l, input bit r, input bit f);
        main_cycle(1'b1, st, l, r, f);
    endtask

    task automatic ov_tick(input bit st, input bit l, input bit f);
        @(negedge clk);
        bus_o.tick = 1; bus_o.start = st; bus_o.btn_left = l; bus_o.btn_fire = f;
        @(posedge clk);
        #1;
        bus_o.tick = 0; bus_o.start = 0; bus_o.btn_left = 0; bus_o.btn_fire = 0;
    endtask

    task automatic a1_cycle(input bit t, input bit st, input bit l, input bit f);
        @(negedge clk);
        bus_a.tick = t; bus_a.start = st; bus_a.btn_left = l; bus_a.btn_fire = f;
        @(posedge clk);
        #1;
        bus_a.tick = 0; bus_a.start = 0; bus_a.btn_left = 0; bus_a.btn_fire = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1;
        model_reset();
        @(negedge clk);
        reset = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 0;
        #1 reset = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus_m.state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", bus_m.state); end
        checks++; if (bus_m.ship_x !== 10'd400) begin errors++; $display("FAIL reset_ship: got %0d want 400", bus_m.ship_x); end
        checks++; if (bus_m.shots_left !== 4'd6) begin errors++; $display("FAIL reset_shots: got %0d want 6", bus_m.shots_left); end
        checks++; if (bus_m.bullet_active !== 1'b0 || bus_m.target_hit !== 4'b0 || bus_m.score !== 8'd0 || bus_m.level_done !== 1'b0) begin
            errors++; $display("FAIL reset_flags: ba=%b hit=%b score=%0d done=%b want 0,0,0,0",
                                bus_m.bullet_active, bus_m.target_hit, bus_m.score, bus_m.level_done); end
        checks++; if (bus_m.target_x !== {10'd140, 10'd100, 10'd60, 10'd20}) begin errors++; $display("FAIL reset_targets: got %h", bus_m.target_x); end
        @(negedge clk);
        reset = 0;
    endtask

    task automatic test_start();
        main_tick(1, 0, 0, 0);
        main_tick(0, 0, 0, 0);
        main_tick(0, 0, 0, 0);
        checks++; if (bus_m.state !== 2'd1) begin errors++; $display("FAIL start_state: got %0d want 1", bus_m.state); end
        checks++; if (bus_m.target_x[9:0] !== 10'd24) begin errors++; $display("FAIL start_t0: got %0d want 24", bus_m.target_x[9:0]); end
        checks++; if (bus_m.target_x[19:10] !== 10'd56) begin errors++; $display("FAIL start_t1: got %0d want 56", bus_m.target_x[19:10]); end
        checks++; if (bus_m.ship_x !== 10'd400 || bus_m.shots_left !== 4'd6) begin
            errors++; $display("FAIL start_ship_ammo: ship=%0d shots=%0d want 400,6", bus_m.ship_x, bus_m.shots_left); end
    endtask

    task automatic test_ship();
        repeat (50) main_tick(0, 0, 1, 0);
        checks++; if (bus_m.ship_x !== 10'd610) begin errors++; $display("FAIL ship_right_limit: got %0d want 610", bus_m.ship_x); end
        repeat (3) main_tick(0, 1, 1, 0);
        checks++; if (bus_m.ship_x !== 10'd610) begin errors++; $display("FAIL ship_both_hold: got %0d want 610", bus_m.ship_x); end
        main_tick(0, 1, 0, 0);
        checks++; if (bus_m.ship_x !== 10'd605) begin errors++; $display("FAIL ship_left_step: got %0d want 605", bus_m.ship_x); end
    endtask

    task automatic test_bounce();
        int p2, p1, cur, mx, mn, v;
        bit saw_top, saw_bot;
        p2 = -1; p1 = -1; mx = 0; mn = 1023; saw_top = 0; saw_bot = 0;
        for (int k = 0; k < 700; k++) begin
            main_tick(0, 0, 0, 0);
            cur = int'(bus_m.target_x[9:0]);
            if (p2 == 610 && p1 == 612 && cur == 610) saw_top = 1;
            if (p2 == 12 && p1 == 10 && cur == 12) saw_bot = 1;
            for (int i = 0; i < 4; i++) begin
                v = int'(bus_m.target_x[i*10 +: 10]);
                if (v > mx) mx = v;
                if (v < mn) mn = v;
            end
            p2 = p1; p1 = cur;
        end
        checks++; if (!saw_top) begin errors++; $display("FAIL bounce_top: 610,612,610 seen=%0d want 1", saw_top); end
        checks++; if (!saw_bot) begin errors++; $display("FAIL bounce_bottom: 12,10,12 seen=%0d want 1", saw_bot); end
        checks++; if (mx > 612 || mn < 10) begin errors++; $display("FAIL bounce_range: min=%0d max=%0d want within 10..612", mn, mx); end
    endtask

    task automatic test_overlap();
        ov_tick(1, 0, 0);
        ov_tick(0, 1, 0);
        ov_tick(0, 1, 0);
        repeat (7) ov_tick(0, 0, 0);
        ov_tick(0, 0, 1);
        checks++; if (bus_o.bullet_active !== 1'b1 || bus_o.bullet_x !== 10'd40 || bus_o.bullet_y !== 10'd435) begin
            errors++; $display("FAIL overlap_fire: ba=%b bx=%0d by=%0d want 1,40,435", bus_o.bullet_active, bus_o.bullet_x, bus_o.bullet_y); end
        checks++; if (bus_o.target_x !== {10'd40, 10'd40}) begin
            errors++; $display("FAIL overlap_align: t1=%0d t0=%0d want 40,40", bus_o.target_x[19:10], bus_o.target_x[9:0]); end
        ov_tick(0, 0, 0);
        checks++; if (bus_o.target_hit !== 2'b01 || bus_o.score !== 8'd1 || bus_o.bullet_active !== 1'b0) begin
            errors++; $display("FAIL overlap_hit: hit=%b score=%0d ba=%b want 01,1,0", bus_o.target_hit, bus_o.score, bus_o.bullet_active); end
        ov_tick(0, 0, 0);
        checks++; if (bus_o.target_x !== {10'd36, 10'd40} || bus_o.shots_left !== 4'd5 || bus_o.state !== 2'd1) begin
            errors++; $display("FAIL overlap_freeze: tx=%h shots=%0d state=%0d want t0=40 t1=36,5,1",
                                bus_o.target_x, bus_o.shots_left, bus_o.state); end
    endtask

    task automatic test_ammo1_win();
        a1_cycle(1, 1, 0, 0);
        a1_cycle(1, 0, 1, 0);
        a1_cycle(1, 0, 1, 0);
        repeat (7) a1_cycle(1, 0, 0, 0);
        a1_cycle(1, 0, 0, 1);
        checks++; if (bus_a.shots_left !== 4'd0 || bus_a.state !== 2'd1) begin
            errors++; $display("FAIL a1_fire: shots=%0d state=%0d want 0,1", bus_a.shots_left, bus_a.state); end
        a1_cycle(1, 0, 0, 0);
        checks++; if (bus_a.state !== 2'd2 || bus_a.level_done !== 1'b1 || bus_a.score !== 8'd1) begin
            errors++; $display("FAIL a1_win: state=%0d done=%b score=%0d want 2,1,1", bus_a.state, bus_a.level_done, bus_a.score); end
        a1_cycle(0, 0, 0, 0);
        checks++; if (bus_a.level_done !== 1'b0 || bus_a.state !== 2'd2) begin
            errors++; $display("FAIL a1_done_pulse: done=%b state=%0d want 0,2", bus_a.level_done, bus_a.state); end
        a1_cycle(1, 0, 1, 1);
        checks++; if (bus_a.state !== 2'd2 || bus_a.ship_x !== 10'd40 || bus_a.level_done !== 1'b0) begin
            errors++; $display("FAIL a1_frozen: state=%0d ship=%0d done=%b want 2,40,0", bus_a.state, bus_a.ship_x, bus_a.level_done); end
        a1_cycle(1, 1, 0, 0);
        checks++; if (bus_a.state !== 2'd1 || bus_a.score !== 8'd1 || bus_a.shots_left !== 4'd1 ||
                      bus_a.target_x !== 10'd20 || bus_a.target_hit !== 1'b0 || bus_a.ship_x !== 10'd400) begin
            errors++; $display("FAIL a1_restart: state=%0d score=%0d shots=%0d tx=%0d hit=%b ship=%0d want 1,1,1,20,0,400",
                                bus_a.state, bus_a.score, bus_a.shots_left, bus_a.target_x, bus_a.target_hit, bus_a.ship_x); end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 400; k++) begin
            main_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                       $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1);
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL random_queue: %0d left want 0", exp_q.size()); end
    endtask

    task automatic test_lose();
        bit done_wait;
        do_reset();
        main_tick(1, 0, 0, 0);
        repeat (100) main_tick(0, 1, 0, 0);
        checks++; if (bus_m.ship_x !== 10'd30) begin errors++; $display("FAIL lose_ship_left_limit: got %0d want 30", bus_m.ship_x); end
        for (int s = 1; s <= 6; s++) begin
            main_tick(0, 0, 0, 1);
            checks++; if (bus_m.bullet_active !== 1'b1) begin errors++; $display("FAIL lose_fire%0d: ba=%b want 1", s, bus_m.bullet_active); end
            done_wait = 0;
            for (int k = 0; k < 60 && !done_wait; k++) begin
                main_tick(0, 0, 0, 0);
                if (!bus_m.bullet_active) done_wait = 1;
            end
            checks++; if (!done_wait) begin errors++; $display("FAIL lose_expire%0d: bullet still active after 60 ticks", s); end
            checks++; if (bus_m.score !== 8'd0) begin errors++; $display("FAIL lose_miss%0d: score=%0d want 0", s, bus_m.score); end
            if (s < 6) begin
                checks++; if (bus_m.state !== 2'd1) begin errors++; $display("FAIL lose_early%0d: state=%0d want 1", s, bus_m.state); end
            end else begin
                checks++; if (bus_m.state !== 2'd3 || bus_m.shots_left !== 4'd0) begin
                    errors++; $display("FAIL lose_state: state=%0d shots=%0d want 3,0", bus_m.state, bus_m.shots_left); end
            end
        end
    endtask

    task automatic test_reset_mid();
        main_tick(1, 0, 0, 0);
        main_tick(0, 0, 0, 1);
        @(negedge clk);
        #2 reset = 1;
        model_reset();
        #1;
        checks++; if (bus_m.state !== 2'd0 || bus_m.bullet_active !== 1'b0 || bus_m.ship_x !== 10'd400 || bus_m.shots_left !== 4'd6) begin
            errors++; $display("FAIL reset_async: state=%0d ba=%b ship=%0d shots=%0d want 0,0,400,6",
                                bus_m.state, bus_m.bullet_active, bus_m.ship_x, bus_m.shots_left); end
        @(negedge clk);
        reset = 0;
        main_tick(0, 0, 1, 1);
        checks++; if (bus_m.state !== 2'd0 || bus_m.ship_x !== 10'd400) begin
            errors++; $display("FAIL reset_needs_start: state=%0d ship=%0d want 0,400", bus_m.state, bus_m.ship_x); end
        main_tick(1, 0, 0, 0);
        checks++; if (bus_m.state !== 2'd1) begin errors++; $display("FAIL reset_restart: state=%0d want 1", bus_m.state); end
    endtask

    initial begin
        bus_m.tick = 0; bus_m.start = 0; bus_m.btn_left = 0; bus_m.btn_right = 0; bus_m.btn_fire = 0;
        bus_o.tick = 0; bus_o.start = 0; bus_o.btn_left = 0; bus_o.btn_right = 0; bus_o.btn_fire = 0;
        bus_a.tick = 0; bus_a.start = 0; bus_a.btn_left = 0; bus_a.btn_right = 0; bus_a.btn_fire = 0;
        test_reset();
        test_start();
        test_ship();
        test_bounce();
        test_overlap();
        test_ammo1_win();
        test_random();
        test_lose();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached with %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end
endmodule
